// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter_pkg
//  Description : Shared definitions for the register-file write arbiter:
//                default widths, the constant-zero register address, the
//                arbitration pointer type and the staged-write record.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_write_arbiter_pkg;

    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 5;

    // Register 0 always reads as zero, so writes to it are dropped.
    localparam logic [c_ADDR_W-1:0] c_ZERO_REG = '0;

    // Round-robin pointer: which requester wins the next contested cycle.
    typedef enum logic [0:0] {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_t;

    // One write held in the staging register.
    typedef struct packed {
        logic                valid;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] data;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-requester round-robin arbiter. Grant is combinational
//                from the request vector and the pointer; the pointer flips
//                only when both requesters ask in the same cycle.
//  Ports       : clk       clock, rising edge
//                rst       asynchronous active-high reset (pointer -> req 0)
//                i_valid   request vector, bit n = requester n
//                o_grant   one-hot grant (all zero during reset / no request)
//                o_ptr     current pointer value
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_valid,
    output logic [1:0] o_grant,
    output logic       o_ptr
);

    ptr_t       r_ptr_q;
    ptr_t       w_ptr_d;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        w_ptr_d = r_ptr_q;
        // Nothing is accepted while reset is held.
        if (!rst) begin
            case (i_valid)
                2'b01: w_grant = 2'b01;
                2'b10: w_grant = 2'b10;
                2'b11: begin
                    w_grant = (r_ptr_q == PTR_REQ0) ? 2'b01 : 2'b10;
                    w_ptr_d = (r_ptr_q == PTR_REQ0) ? PTR_REQ1 : PTR_REQ0;
                end
                default: w_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_q <= PTR_REQ0;
        end else begin
            r_ptr_q <= w_ptr_d;
        end
    end

    assign o_grant = w_grant;
    assign o_ptr   = r_ptr_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Arbitrates two write requesters onto a single register-file
//                write port through a one-cycle staging register, and detects
//                read-after-write hazards against the staged write.
//                Optional macro REGFILE_WRITE_ARBITER_BYPASS_EN: forward the
//                staged data to the read ports instead of raising Stall.
//  Ports       : Clk, Reset                 clock / async active-high reset
//                Valid0/1, Addr0/1, Data0/1 write requests
//                Ready0/1                   request accepted this cycle
//                RegWrite, WriteRegister,
//                WriteData                  register-file write port
//                ReadRegister1/2            consumer read addresses
//                RfReadData1/2              raw register-file read data
//                ReadData1/2                read data to the consumer
//                Stall                      hazard against the staged write
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Valid0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] Data0,
    input  logic              Valid1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Data1,
    output logic              Ready0,
    output logic              Ready1,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] RfReadData1,
    input  logic [DATA_W-1:0] RfReadData2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              Stall
);

    logic [1:0] w_grant;
    logic       w_ptr;
    stage_t     r_stage_q;
    stage_t     w_stage_d;
    logic       w_hit1;
    logic       w_hit2;

    rr_arb2 u_arb (
        .clk     (Clk),
        .rst     (Reset),
        .i_valid ({Valid1, Valid0}),
        .o_grant (w_grant),
        .o_ptr   (w_ptr)
    );

    // Address/data only move on a real write so they hold while RegWrite=0.
    // A grant to register 0 is accepted but leaves the stage idle.
    always_comb begin
        w_stage_d       = r_stage_q;
        w_stage_d.valid = 1'b0;
        if (w_grant[0] && (Addr0 != c_ZERO_REG)) begin
            w_stage_d.valid = 1'b1;
            w_stage_d.addr  = Addr0;
            w_stage_d.data  = Data0;
        end else if (w_grant[1] && (Addr1 != c_ZERO_REG)) begin
            w_stage_d.valid = 1'b1;
            w_stage_d.addr  = Addr1;
            w_stage_d.data  = Data1;
        end
    end

    // Asynchronous clear also discards any write staged when reset hits.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_stage_q <= '0;
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign Ready0        = w_grant[0];
    assign Ready1        = w_grant[1];
    assign RegWrite      = r_stage_q.valid;
    assign WriteRegister = r_stage_q.addr;
    assign WriteData     = r_stage_q.data;

    assign w_hit1 = r_stage_q.valid && (ReadRegister1 != c_ZERO_REG)
                    && (r_stage_q.addr == ReadRegister1);
    assign w_hit2 = r_stage_q.valid && (ReadRegister2 != c_ZERO_REG)
                    && (r_stage_q.addr == ReadRegister2);

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    assign ReadData1 = w_hit1 ? r_stage_q.data : RfReadData1;
    assign ReadData2 = w_hit2 ? r_stage_q.data : RfReadData2;
    assign Stall     = 1'b0;
`else
    assign ReadData1 = RfReadData1;
    assign ReadData2 = RfReadData2;
    assign Stall     = w_hit1 || w_hit2;
`endif

    // Pointer state is internal to the arbiter; kept visible for debug only.
    logic w_unused;
    assign w_unused = w_ptr;

endmodule
`default_nettype wire
